// File: rtl/bpsk_modem_loopback.sv
// BPSK loopback: sine-table modulator, LFSR noise, clamped noise adder and a
// correlating demodulator. One symbol per 16 clocks; the cnt==15 edge is the boundary.
module bpsk_modem_loopback #(
  parameter logic [14:0] LFSR_SEED = 15'h0001,
  parameter logic [7:0]  MID       = 8'd128
) (
  input  logic       clk_fast,
  input  logic       rst,
  input  logic       valid,
  input  logic       bit_in,
  input  logic       noise_en,
  output logic [7:0] wav_sine,
  output logic [5:0] wav_noise,
  output logic [7:0] wav_out,
  output logic       bit_out,
  output logic       dem_valid
);

  logic [3:0]         cnt_q, cnt_d;
  logic               cur_bit_q, cur_bit_d;
  logic               cur_valid_q, cur_valid_d;
  logic [14:0]        lfsr_q, lfsr_d;
  logic signed [12:0] acc_q, acc_d;
  logic               bit_out_q, bit_out_d;
  logic               dem_valid_q, dem_valid_d;

  logic               boundary;
  logic [3:0]         sine_idx;
  logic [7:0]         sine_val;
  logic [7:0]         noise_mag;
  logic [7:0]         dem_in;
  logic signed [8:0]  x;
  logic signed [12:0] x_ext;
  logic signed [12:0] wx;
  logic signed [12:0] acc_final;

  // Modulator: bit 0 is the same table read half a carrier period later.
  always_comb begin
    sine_idx = cur_bit_q ? cnt_q : cnt_q + 4'd8;
    case (sine_idx)
      4'd0:    sine_val = 8'd128;
      4'd1:    sine_val = 8'd165;
      4'd2:    sine_val = 8'd196;
      4'd3:    sine_val = 8'd217;
      4'd4:    sine_val = 8'd224;
      4'd5:    sine_val = 8'd217;
      4'd6:    sine_val = 8'd196;
      4'd7:    sine_val = 8'd165;
      4'd8:    sine_val = 8'd128;
      4'd9:    sine_val = 8'd91;
      4'd10:   sine_val = 8'd60;
      4'd11:   sine_val = 8'd39;
      4'd12:   sine_val = 8'd32;
      4'd13:   sine_val = 8'd39;
      4'd14:   sine_val = 8'd60;
      default: sine_val = 8'd91;
    endcase
    wav_sine  = cur_valid_q ? sine_val : MID;
    wav_noise = lfsr_q[5:0];
  end

  // Channel: carrier peak is 224 and noise is at most 30, so the add cannot wrap.
  always_comb begin
    noise_mag = {3'b000, wav_noise[3:0], 1'b0};
    if (!wav_noise[4]) begin
      wav_out = wav_sine + noise_mag;
    end else if (noise_mag < wav_sine) begin
      wav_out = wav_sine - noise_mag;
    end else begin
      wav_out = 8'd0;
    end
  end

  // Demodulator: correlate against a square reference, zero weight at the zero crossings.
  always_comb begin
    dem_in = noise_en ? wav_out : wav_sine;
    x      = $signed({1'b0, dem_in}) - 9'sd128;
    x_ext  = {{4{x[8]}}, x};
    if (cnt_q >= 4'd1 && cnt_q <= 4'd7) begin
      wx = x_ext;
    end else if (cnt_q >= 4'd9) begin
      wx = -x_ext;
    end else begin
      wx = 13'sd0;
    end
    acc_final = acc_q + wx;
  end

  always_comb begin
    boundary    = (cnt_q == 4'd15);
    cnt_d       = cnt_q + 4'd1;
    lfsr_d      = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
    cur_bit_d   = cur_bit_q;
    cur_valid_d = cur_valid_q;
    acc_d       = acc_final;
    bit_out_d   = bit_out_q;
    dem_valid_d = dem_valid_q;
    if (boundary) begin
      cur_bit_d   = bit_in;
      cur_valid_d = valid;
      acc_d       = 13'sd0;
      bit_out_d   = (acc_final > 13'sd0);
      dem_valid_d = cur_valid_q;
    end
  end

  always_ff @(posedge clk_fast) begin
    if (!rst) begin
      cnt_q       <= 4'd0;
      cur_bit_q   <= 1'b0;
      cur_valid_q <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      acc_q       <= 13'sd0;
      bit_out_q   <= 1'b0;
      dem_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cur_bit_q   <= cur_bit_d;
      cur_valid_q <= cur_valid_d;
      lfsr_q      <= lfsr_d;
      acc_q       <= acc_d;
      bit_out_q   <= bit_out_d;
      dem_valid_q <= dem_valid_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign dem_valid = dem_valid_q;

endmodule

// File: tb/tb_bpsk_modem_loopback.sv
// Directed bench for bpsk_modem_loopback: hand-computed carrier, channel and
// reset vectors plus a cycle-level reference model of the loopback.
module tb_bpsk_modem_loopback;

  logic       clk_fast = 1'b0;
  logic       rst;
  logic       valid;
  logic       bit_in;
  logic       noise_en;
  logic [7:0] wav_sine;
  logic [5:0] wav_noise;
  logic [7:0] wav_out;
  logic       bit_out;
  logic       dem_valid;

  int checks   = 0;
  int failures = 0;

  bpsk_modem_loopback dut (
    .clk_fast (clk_fast),
    .rst      (rst),
    .valid    (valid),
    .bit_in   (bit_in),
    .noise_en (noise_en),
    .wav_sine (wav_sine),
    .wav_noise(wav_noise),
    .wav_out  (wav_out),
    .bit_out  (bit_out),
    .dem_valid(dem_valid)
  );

  always #5 clk_fast = ~clk_fast;

  logic [7:0]  s_tab    [16] = '{8'd128, 8'd165, 8'd196, 8'd217, 8'd224, 8'd217, 8'd196, 8'd165,
                                 8'd128, 8'd91,  8'd60,  8'd39,  8'd32,  8'd39,  8'd60,  8'd91};
  logic [7:0]  exp_one  [16] = '{8'd128, 8'd165, 8'd196, 8'd217, 8'd224, 8'd217, 8'd196, 8'd165,
                                 8'd128, 8'd91,  8'd60,  8'd39,  8'd32,  8'd39,  8'd60,  8'd91};
  logic [7:0]  exp_zero [16] = '{8'd128, 8'd91,  8'd60,  8'd39,  8'd32,  8'd39,  8'd60,  8'd91,
                                 8'd128, 8'd165, 8'd196, 8'd217, 8'd224, 8'd217, 8'd196, 8'd165};
  logic [5:0]  exp_noise [6] = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h00};

  logic [14:0] m_lfsr;
  logic [3:0]  m_cnt;
  logic        m_bit, m_valid;
  logic        e_bit, e_dv, e_care;
  int          hit224 = 0;
  int          hit32  = 0;
  int          hit128 = 0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [14:0] lfsr_next(input logic [14:0] l);
    return {l[13:0], l[14] ^ l[13]};
  endfunction

  // Looks ahead over the next symbol for noise words that land on the carrier
  // peak or trough, and picks the bit that puts them on 224 or 32.
  function automatic int pick_bit(input logic [14:0] l0);
    logic [14:0] l;
    int r;
    l = l0;
    r = -1;
    for (int k = 0; k < 16; k++) begin
      l = lfsr_next(l);
      if (r < 0 && k == 4) begin
        if (l[4:0] == 5'h0F) r = 1;
        else if (l[4:0] == 5'h1F) r = 0;
      end else if (r < 0 && k == 12) begin
        if (l[4:0] == 5'h0F) r = 0;
        else if (l[4:0] == 5'h1F) r = 1;
      end
    end
    return r;
  endfunction

  task automatic model_edge();
    if (!rst) begin
      m_cnt   = 4'd0;
      m_bit   = 1'b0;
      m_valid = 1'b0;
      m_lfsr  = 15'h0001;
      e_bit   = 1'b0;
      e_dv    = 1'b0;
      e_care  = 1'b1;
    end else begin
      if (m_cnt == 4'd15) begin
        e_care  = m_valid | ~noise_en;
        e_bit   = m_valid & m_bit;
        e_dv    = m_valid;
        m_bit   = bit_in;
        m_valid = valid;
      end
      m_cnt  = m_cnt + 4'd1;
      m_lfsr = lfsr_next(m_lfsr);
    end
  endtask

  task automatic model_check();
    int s, mm, wo;
    logic [5:0] n;
    n  = m_lfsr[5:0];
    s  = !m_valid ? 128 : m_bit ? int'(s_tab[m_cnt]) : int'(s_tab[4'(m_cnt + 4'd8)]);
    mm = int'(n[3:0]) * 2;
    wo = n[4] ? ((s - mm < 0) ? 0 : s - mm) : s + mm;
    check_val("m_sine", 16'(wav_sine), 16'(s));
    check_val("m_noise", 16'(wav_noise), 16'(n));
    check_val("m_out", 16'(wav_out), 16'(wo));
    check_val("m_dem_valid", 16'(dem_valid), 16'(e_dv));
    if (e_care) check_val("m_bit_out", 16'(bit_out), 16'(e_bit));
    if (n[4:0] == 5'h0F && s == 224) begin
      hit224++;
      check_val("ch_224_0f", 16'(wav_out), 16'd254);
    end
    if (n[4:0] == 5'h1F && s == 32) begin
      hit32++;
      check_val("ch_32_1f", 16'(wav_out), 16'd2);
    end
    if (n[4:0] == 5'h10 && s == 128) begin
      hit128++;
      check_val("ch_128_10", 16'(wav_out), 16'd128);
    end
  endtask

  task automatic tick();
    @(posedge clk_fast);
    #1;
    model_edge();
    model_check();
  endtask

  task automatic to_boundary();
    for (int i = 0; i < 16 && m_cnt != 4'd15; i++) tick();
  endtask

  task automatic loop_symbols(input int n);
    int p;
    for (int i = 0; i < n; i++) begin
      p      = pick_bit(m_lfsr);
      valid  = 1'b1;
      bit_in = (p < 0) ? 1'($urandom_range(0, 1)) : 1'(p);
      for (int k = 0; k < 16; k++) tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; valid = 1'b0; bit_in = 1'b0; noise_en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_val("rst_sine", 16'(wav_sine), 16'd128);
    check_val("rst_noise", 16'(wav_noise), 16'h01);
    check_val("rst_bit_out", 16'(bit_out), 16'd0);
    check_val("rst_dem_valid", 16'(dem_valid), 16'd0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("lfsr_seq", 16'(wav_noise), 16'(exp_noise[i]));
    end
    to_boundary();

    valid = 1'b1; bit_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_val("carrier_one", 16'(wav_sine), 16'(exp_one[i]));
    end
    bit_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_val("carrier_zero", 16'(wav_sine), 16'(exp_zero[i]));
    end

    loop_symbols(200);
    noise_en = 1'b1;
    loop_symbols(200);
    noise_en = 1'b0;
    loop_symbols(2);

    valid = 1'b0; bit_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_val("idle_sine", 16'(wav_sine), 16'd128);
    end
    valid = 1'b1; bit_in = 1'b1;
    tick();
    check_val("idle_dem_valid", 16'(dem_valid), 16'd0);
    check_val("idle_bit_out", 16'(bit_out), 16'd0);
    for (int i = 0; i < 15; i++) tick();
    bit_in = 1'b0;
    tick();
    check_val("resume_dem_valid", 16'(dem_valid), 16'd1);
    check_val("resume_bit_out", 16'(bit_out), 16'd1);
    for (int i = 0; i < 15; i++) tick();

    for (int i = 0; i < 8 && m_cnt != 4'd7; i++) tick();
    check_val("pre_rst_dem_valid", 16'(dem_valid), 16'd1);
    rst = 1'b0;
    tick();
    check_val("mid_rst_sine", 16'(wav_sine), 16'd128);
    check_val("mid_rst_noise", 16'(wav_noise), 16'h01);
    check_val("mid_rst_bit_out", 16'(bit_out), 16'd0);
    check_val("mid_rst_dem_valid", 16'(dem_valid), 16'd0);
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check_val("post_rst_no_dv", 16'(dem_valid), 16'd0);
    end
    valid = 1'b1; bit_in = 1'b1;
    tick();
    check_val("restart_cnt0", 16'(wav_sine), 16'd128);
    check_val("restart_dv_low", 16'(dem_valid), 16'd0);
    tick();
    check_val("restart_cnt1", 16'(wav_sine), 16'd165);
    for (int i = 0; i < 14; i++) tick();
    loop_symbols(4);

    check_val("hit_224_0f", 16'(hit224 > 0), 16'd1);
    check_val("hit_32_1f", 16'(hit32 > 0), 16'd1);
    check_val("hit_128_10", 16'(hit128 > 0), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
